// File: rtl/dgt_rdata_fetcher_if.sv
// Index-in / data-out stream bundle for the read-data fetcher.
// The slave view is the fetcher; the master view is whoever drives indices and consumes words.
interface dgt_rdata_fetcher_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 256
);
    // Index channel
    logic                  idx_valid;
    logic                  idx_ready;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  idx_last;

    // Data channel
    logic                  data_valid;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;

    modport master (
        output idx_valid, idx, idx_last, data_ready,
        input  idx_ready, data_valid, data, addr, last
    );

    modport slave (
        input  idx_valid, idx, idx_last, data_ready,
        output idx_ready, data_valid, data, addr, last
    );
endinterface

// File: rtl/dgt_rdata_fetcher.sv
// Read-data fetcher: accepts block indices, issues fixed-latency SRAM reads, buffers the
// returned words with their address/last tags in a credit-protected FIFO and streams them out.
// An empty FIFO is bypassed so a return reaches the output in the cycle it arrives.
module dgt_rdata_fetcher #(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   flush_i,
    dgt_rdata_fetcher_if.slave     strm_io,
    output logic                   mem_ren_o,
    output logic [ADDR_WIDTH-1:0]  mem_raddr_o,
    input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = DATA_WIDTH + ADDR_WIDTH + 1;

    // Delay line tracking reads whose data is still inside the SRAM
    logic [MEM_LATENCY-1:0]                 dl_vld_q;
    logic [MEM_LATENCY-1:0][ADDR_WIDTH-1:0] dl_addr_q;
    logic [MEM_LATENCY-1:0]                 dl_last_q;

    // Response FIFO, entry layout {last, addr, data}
    logic [EntW-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] credit_q;

    logic            accept;
    logic            ret_vld;
    logic            empty;
    logic            pop;
    logic            fifo_pop;
    logic            wr_en;
    logic [EntW-1:0] head;

    assign empty    = (count_q == '0);
    assign head     = fifo_mem_q[rd_ptr_q];
    assign ret_vld  = dl_vld_q[MEM_LATENCY-1] & ~flush_i;

    assign strm_io.idx_ready  = en_i & ~flush_i & (credit_q != '0);
    assign accept             = strm_io.idx_valid & strm_io.idx_ready;
    assign mem_ren_o          = accept;
    assign mem_raddr_o        = accept ? strm_io.idx : '0;

    assign strm_io.data_valid = ~flush_i & (~empty | ret_vld);
    assign pop                = strm_io.data_valid & strm_io.data_ready;
    assign fifo_pop           = pop & ~empty;
    // A return consumed straight from the bypass path never enters storage
    assign wr_en              = ret_vld & ~(empty & pop);

    assign done_o = pop & strm_io.last;
    assign busy_o = (|dl_vld_q) | ~empty;

    // Output word: FIFO head when buffered, otherwise the arriving return, otherwise zero
    always_comb begin
        strm_io.data = '0;
        strm_io.addr = '0;
        strm_io.last = 1'b0;
        if (!empty) begin
            strm_io.data = head[DATA_WIDTH-1:0];
            strm_io.addr = head[DATA_WIDTH +: ADDR_WIDTH];
            strm_io.last = head[EntW-1];
        end else if (ret_vld) begin
            strm_io.data = mem_rdata_i;
            strm_io.addr = dl_addr_q[MEM_LATENCY-1];
            strm_io.last = dl_last_q[MEM_LATENCY-1];
        end
    end

    // Control state: delay line, pointers, occupancy and credit; flush has priority
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dl_vld_q  <= '0;
            dl_addr_q <= '0;
            dl_last_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            credit_q  <= CntW'(FIFO_DEPTH);
        end else if (flush_i) begin
            dl_vld_q  <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            credit_q  <= CntW'(FIFO_DEPTH);
        end else begin
            dl_vld_q[0]  <= accept;
            dl_addr_q[0] <= strm_io.idx;
            dl_last_q[0] <= strm_io.idx_last;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                dl_vld_q[i]  <= dl_vld_q[i-1];
                dl_addr_q[i] <= dl_addr_q[i-1];
                dl_last_q[i] <= dl_last_q[i-1];
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q  <= count_q + CntW'(wr_en) - CntW'(fifo_pop);
            // Credit covers both in-flight reads and buffered words, so only accept/pop move it
            credit_q <= credit_q - CntW'(accept) + CntW'(pop);
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            fifo_mem_q[wr_ptr_q] <= {dl_last_q[MEM_LATENCY-1], dl_addr_q[MEM_LATENCY-1],
                                     mem_rdata_i};
        end
    end

endmodule

// File: tb/tb_dgt_rdata_fetcher.sv
// Directed bench for dgt_rdata_fetcher: one instance at MEM_LATENCY=1, one at MEM_LATENCY=2.
module tb_dgt_rdata_fetcher;
    localparam int AW = 6;
    localparam int DW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic          en1, flush1, ren1, busy1, done1;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1 = '0;
    logic          en2, flush2, ren2, busy2, done2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2_a = '0;
    logic [DW-1:0] rdata2 = '0;

    dgt_rdata_fetcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
    dgt_rdata_fetcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

    dgt_rdata_fetcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en1), .flush_i(flush1), .strm_io(if1),
        .mem_ren_o(ren1), .mem_raddr_o(raddr1), .mem_rdata_i(rdata1),
        .busy_o(busy1), .done_o(done1)
    );

    dgt_rdata_fetcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(2), .FIFO_DEPTH(4)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .flush_i(flush2), .strm_io(if2),
        .mem_ren_o(ren2), .mem_raddr_o(raddr2), .mem_rdata_i(rdata2),
        .busy_o(busy2), .done_o(done2)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {26'h2A55A5, a};
        return {8{w}};
    endfunction

    // SRAM models with 1 and 2 cycles of read latency
    always @(posedge clk) begin
        rdata1   <= mem_word(raddr1);
        rdata2_a <= mem_word(raddr2);
        rdata2   <= rdata2_a;
    end

    // Overflow watch on both buffers
    always @(negedge clk) begin
        if (rst_n && (u_dut1.count_q > 3'd4 || u_dut2.count_q > 3'd4)) begin
            failures++;
            $display("FAIL overflow count1=%0d count2=%0d max=4", u_dut1.count_q, u_dut2.count_q);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (if1.idx_ready !== 1'b0) begin failures++;
            $display("FAIL rst_idx_ready got=%b exp=0", if1.idx_ready); end
        checks++; if (if1.data_valid !== 1'b0) begin failures++;
            $display("FAIL rst_data_valid got=%b exp=0", if1.data_valid); end
        checks++; if ({ren1, raddr1, busy1, done1} !== '0) begin failures++;
            $display("FAIL rst_ctrl got=%b%h%b%b exp=0", ren1, raddr1, busy1, done1); end
        checks++; if ({if1.data, if1.addr, if1.last} !== '0) begin failures++;
            $display("FAIL rst_word got=%h/%h/%b exp=0", if1.data, if1.addr, if1.last); end
        checks++; if ({if2.data_valid, busy2, done2} !== 3'b000) begin failures++;
            $display("FAIL rst_dut2 got=%b%b%b exp=000", if2.data_valid, busy2, done2); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        en1 = 1'b1;
        en2 = 1'b1;
        mid();
        checks++; if (if1.idx_ready !== 1'b1 || if2.idx_ready !== 1'b1) begin failures++;
            $display("FAIL rst_credit_ready got=%b%b exp=11", if1.idx_ready, if2.idx_ready); end
    endtask

    task automatic test_single();
        step();
        if1.idx_valid = 1'b1; if1.idx = 6'd5; if1.idx_last = 1'b1; if1.data_ready = 1'b1;
        mid();
        checks++; if (ren1 !== 1'b1 || raddr1 !== 6'd5) begin failures++;
            $display("FAIL single_issue got=%b/%0d exp=1/5", ren1, raddr1); end
        step();
        if1.idx_valid = 1'b0; if1.idx = '0; if1.idx_last = 1'b0;
        mid();
        checks++; if (if1.data_valid !== 1'b1 || if1.addr !== 6'd5 || if1.last !== 1'b1) begin
            failures++;
            $display("FAIL single_out got=%b/%0d/%b exp=1/5/1", if1.data_valid, if1.addr, if1.last);
        end
        checks++; if (if1.data !== mem_word(6'd5)) begin failures++;
            $display("FAIL single_data got=%h exp=%h", if1.data, mem_word(6'd5)); end
        checks++; if (done1 !== 1'b1) begin failures++;
            $display("FAIL single_done got=%b exp=1", done1); end
        step();
        mid();
        checks++; if (busy1 !== 1'b0 || if1.data_valid !== 1'b0) begin failures++;
            $display("FAIL single_idle got=%b/%b exp=0/0", busy1, if1.data_valid); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int e = 0;
        if1.data_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if1.idx_valid = 1'b1; if1.idx = AW'(n); if1.idx_last = (n == 9);
            mid();
            if (if1.idx_ready) n++;
        end
        checks++; if (n !== 4) begin failures++;
            $display("FAIL bp_accepts got=%0d exp=4", n); end
        checks++; if (if1.idx_ready !== 1'b0) begin failures++;
            $display("FAIL bp_stalled got=%b exp=0", if1.idx_ready); end
        for (int c = 0; c < 30 && e < 10; c++) begin
            step();
            if1.data_ready = 1'b1;
            if1.idx_valid = (n < 10); if1.idx = AW'(n); if1.idx_last = (n == 9);
            mid();
            if (c == 0) begin
                checks++; if (if1.idx_ready !== 1'b0) begin failures++;
                    $display("FAIL bp_ready_first_pop got=%b exp=0", if1.idx_ready); end
            end
            if (c == 1) begin
                checks++; if (if1.idx_ready !== 1'b1) begin failures++;
                    $display("FAIL bp_ready_after_pop got=%b exp=1", if1.idx_ready); end
            end
            if (if1.idx_valid && if1.idx_ready) n++;
            if (if1.data_valid) begin
                checks++;
                if (if1.addr !== AW'(e) || if1.data !== mem_word(AW'(e)) || done1 !== (e == 9))
                begin
                    failures++;
                    $display("FAIL bp_order got=%0d done=%b exp=%0d", if1.addr, done1, e);
                end
                e++;
            end
        end
        checks++; if (e !== 10 || n !== 10) begin failures++;
            $display("FAIL bp_complete got=%0d/%0d exp=10/10", e, n); end
        step();
        if1.idx_valid = 1'b0; if1.idx_last = 1'b0;
        mid();
        checks++; if (busy1 !== 1'b0) begin failures++;
            $display("FAIL bp_idle got=%b exp=0", busy1); end
    endtask

    task automatic test_full_rate();
        int words = 0;
        int dones = 0;
        if2.data_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            if2.idx_valid = (c < 8); if2.idx = AW'(10 + c); if2.idx_last = (c == 7);
            mid();
            if (c < 8) begin
                checks++; if (if2.idx_ready !== 1'b1) begin failures++;
                    $display("FAIL fr_ready c=%0d got=%b exp=1", c, if2.idx_ready); end
            end
            checks++; if (if2.data_valid !== (c >= 2 && c < 10)) begin failures++;
                $display("FAIL fr_valid c=%0d got=%b exp=%b", c, if2.data_valid, (c >= 2 && c < 10));
            end
            if (if2.data_valid) begin
                checks++;
                if (if2.addr !== AW'(8 + c) || if2.data !== mem_word(AW'(8 + c))) begin
                    failures++;
                    $display("FAIL fr_word c=%0d got=%0d exp=%0d", c, if2.addr, 8 + c);
                end
                words++;
            end
            if (done2) begin
                dones++;
                checks++; if (if2.addr !== 6'd17) begin failures++;
                    $display("FAIL fr_done_addr got=%0d exp=17", if2.addr); end
            end
        end
        checks++; if (words !== 8 || dones !== 1) begin failures++;
            $display("FAIL fr_counts got=%0d/%0d exp=8/1", words, dones); end
    endtask

    task automatic test_push_pop_full();
        if1.data_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if1.idx_valid = 1'b1; if1.idx = AW'(20 + c); if1.idx_last = 1'b0;
            mid();
        end
        step();
        if1.idx_valid = 1'b0;
        mid();
        step();
        mid();
        checks++; if (u_dut1.count_q !== 3'd4 || if1.idx_ready !== 1'b0) begin failures++;
            $display("FAIL pp_full got=%0d/%b exp=4/0", u_dut1.count_q, if1.idx_ready); end
        step();
        if1.data_ready = 1'b1; if1.idx_valid = 1'b1; if1.idx = 6'd24;
        mid();
        checks++; if (if1.addr !== 6'd20 || if1.idx_ready !== 1'b0) begin failures++;
            $display("FAIL pp_pop20 got=%0d/%b exp=20/0", if1.addr, if1.idx_ready); end
        step();
        if1.data_ready = 1'b0;
        mid();
        checks++; if (if1.idx_ready !== 1'b1) begin failures++;
            $display("FAIL pp_regain got=%b exp=1", if1.idx_ready); end
        step();
        if1.idx_valid = 1'b0; if1.data_ready = 1'b1;
        mid();
        checks++; if (u_dut1.count_q !== 3'd3 || if1.addr !== 6'd21) begin failures++;
            $display("FAIL pp_pre got=%0d/%0d exp=3/21", u_dut1.count_q, if1.addr); end
        for (int k = 22; k <= 24; k++) begin
            step();
            mid();
            if (k == 22) begin
                checks++; if (u_dut1.count_q !== 3'd3) begin failures++;
                    $display("FAIL pp_count_held got=%0d exp=3", u_dut1.count_q); end
            end
            checks++;
            if (if1.data_valid !== 1'b1 || if1.addr !== AW'(k) || if1.data !== mem_word(AW'(k)))
            begin
                failures++;
                $display("FAIL pp_drain got=%b/%0d exp=1/%0d", if1.data_valid, if1.addr, k);
            end
        end
        step();
        mid();
        checks++; if (if1.data_valid !== 1'b0 || busy1 !== 1'b0) begin failures++;
            $display("FAIL pp_empty got=%b/%b exp=0/0", if1.data_valid, busy1); end
    endtask

    task automatic test_flush();
        if2.data_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if2.idx_valid = 1'b1; if2.idx = AW'(30 + c); if2.idx_last = (c == 3);
            mid();
        end
        step();
        flush2 = 1'b1; if2.idx = 6'd35; if2.idx_last = 1'b0;
        mid();
        checks++; if (u_dut2.count_q !== 3'd2 || u_dut2.dl_vld_q !== 2'b11) begin failures++;
            $display("FAIL fl_pre got=%0d/%b exp=2/11", u_dut2.count_q, u_dut2.dl_vld_q); end
        checks++; if ({if2.idx_ready, if2.data_valid, done2, ren2} !== 4'b0000) begin failures++;
            $display("FAIL fl_cycle got=%b%b%b%b exp=0000", if2.idx_ready, if2.data_valid,
                     done2, ren2);
        end
        step();
        flush2 = 1'b0; if2.idx = 6'd3; if2.idx_last = 1'b1; if2.data_ready = 1'b1;
        mid();
        checks++; if (if2.data_valid !== 1'b0 || busy2 !== 1'b0) begin failures++;
            $display("FAIL fl_after got=%b/%b exp=0/0", if2.data_valid, busy2); end
        checks++; if (u_dut2.credit_q !== 3'd4 || if2.idx_ready !== 1'b1) begin failures++;
            $display("FAIL fl_credit got=%0d/%b exp=4/1", u_dut2.credit_q, if2.idx_ready); end
        step();
        if2.idx_valid = 1'b0; if2.idx_last = 1'b0;
        mid();
        checks++; if (if2.data_valid !== 1'b0) begin failures++;
            $display("FAIL fl_stale got=%b addr=%0d exp=0", if2.data_valid, if2.addr); end
        step();
        mid();
        checks++;
        if (if2.data_valid !== 1'b1 || if2.addr !== 6'd3 || if2.data !== mem_word(6'd3) ||
            done2 !== 1'b1) begin
            failures++;
            $display("FAIL fl_refetch got=%b/%0d/%b exp=1/3/1", if2.data_valid, if2.addr, done2);
        end
    endtask

    task automatic test_en_low();
        if1.data_ready = 1'b1;
        step();
        if1.idx_valid = 1'b1; if1.idx = 6'd40;
        mid();
        step();
        if1.idx = 6'd41;
        mid();
        checks++; if (if1.data_valid !== 1'b1 || if1.addr !== 6'd40) begin failures++;
            $display("FAIL en_out40 got=%b/%0d exp=1/40", if1.data_valid, if1.addr); end
        step();
        en1 = 1'b0; if1.idx = 6'd42;
        mid();
        checks++; if (if1.idx_ready !== 1'b0 || ren1 !== 1'b0) begin failures++;
            $display("FAIL en_block got=%b/%b exp=0/0", if1.idx_ready, ren1); end
        checks++; if (if1.data_valid !== 1'b1 || if1.addr !== 6'd41) begin failures++;
            $display("FAIL en_inflight got=%b/%0d exp=1/41", if1.data_valid, if1.addr); end
        step();
        mid();
        checks++; if ({if1.idx_ready, ren1, if1.data_valid, busy1} !== 4'b0000) begin failures++;
            $display("FAIL en_hold got=%b%b%b%b exp=0000", if1.idx_ready, ren1, if1.data_valid,
                     busy1);
        end
        step();
        en1 = 1'b1;
        mid();
        step();
        if1.idx_valid = 1'b0;
        mid();
        checks++; if (if1.data_valid !== 1'b1 || if1.addr !== 6'd42) begin failures++;
            $display("FAIL en_resume got=%b/%0d exp=1/42", if1.data_valid, if1.addr); end
    endtask

    task automatic test_reset_mid();
        if1.data_ready = 1'b0;
        step();
        if1.idx_valid = 1'b1; if1.idx = 6'd50;
        mid();
        step();
        if1.idx = 6'd51;
        mid();
        step();
        if1.idx_valid = 1'b0; en1 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy1, if1.data_valid, if1.idx_ready, done1} !== 4'b0000) begin
            failures++;
            $display("FAIL rm_async got=%b%b%b%b exp=0000", busy1, if1.data_valid,
                     if1.idx_ready, done1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        en1 = 1'b1;
        mid();
        checks++; if (if1.data_valid !== 1'b0 || busy1 !== 1'b0) begin failures++;
            $display("FAIL rm_ignored got=%b/%b exp=0/0", if1.data_valid, busy1); end
    endtask

    initial begin
        en1 = 1'b0; flush1 = 1'b0; en2 = 1'b0; flush2 = 1'b0;
        if1.idx_valid = 1'b0; if1.idx = '0; if1.idx_last = 1'b0; if1.data_ready = 1'b0;
        if2.idx_valid = 1'b0; if2.idx = '0; if2.idx_last = 1'b0; if2.data_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_full_rate();
        test_push_pop_full();
        test_flush();
        test_en_low();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
